// File: rtl/button_event_reader.sv
// button_event_reader: samples up to 8 button pins, debounces each channel and
// queues per-channel press (and optionally release) events over valid/ready.
// Optional feature macro: BTN_RELEASE_EVT_EN (queue release events too).
module button_event_reader #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_chan,
  output logic             evt_kind,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] IDLE_LVL = {WIDTH{ACTIVE_LOW != 0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_L  = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] sync1, sync2, s;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] done, new_evt, pend, grant;
`ifdef BTN_RELEASE_EVT_EN
  logic [WIDTH-1:0] kind;
`endif
  logic             found, push, pop, full, push_kind;
  logic [2:0]       grant_idx;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  // Two-flop synchronizer; reset loads the not-pressed pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so that s[i]==1 means pressed.
  always_comb begin
    s = sync2;
    if (ACTIVE_LOW != 0) s = ~sync2;
  end

  // Debounce commit condition and which commits become events.
  always_comb begin
    done    = '0;
    new_evt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      done[i] = (s[i] != btn_state[i]) && (cnt[i] == CNT_MAX);
`ifdef BTN_RELEASE_EVT_EN
      new_evt[i] = done[i];
`else
      new_evt[i] = done[i] && s[i];
`endif
    end
  end

  // Per-channel stability counters and debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_state <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_state[i] <= s[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed-priority arbiter: lowest-index pending channel wins the push slot.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    push_kind = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = 3'(i);
        found     = 1'b1;
`ifdef BTN_RELEASE_EVT_EN
        push_kind = kind[i];
`endif
      end
    end
  end

  assign full = (count == DEPTH_L);
  assign pop  = evt_valid && evt_ready;
  assign push = found && (!full || pop);

  // Pending flags. A new commit on a channel whose previous event is still
  // pending (and not leaving this cycle) replaces it and marks the loss; when
  // releases are not queued, a release replaces a pending press with nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      overflow <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
      kind     <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (done[i]) begin
          pend[i] <= new_evt[i];
`ifdef BTN_RELEASE_EVT_EN
          kind[i] <= s[i];
`endif
        end else if (grant[i] && push) begin
          pend[i] <= 1'b0;
        end
      end
      if (|(done & pend & ~(grant & {WIDTH{push}}))) overflow <= 1'b1;
    end
  end

  // Event queue storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_idx, push_kind};
  end

  // Event queue pointers and occupancy; push and pop may coincide even when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue outputs, forced to zero while the queue is empty.
  always_comb begin
    evt_valid = (count != '0);
    evt_chan  = '0;
    evt_kind  = 1'b0;
    if (evt_valid) begin
      evt_chan = mem[rd_ptr][3:1];
      evt_kind = mem[rd_ptr][0];
    end
  end

endmodule

// File: tb/tb_button_event_reader.sv
// Directed self-checking bench for button_event_reader (DEBOUNCE_CYCLES=4).
// Expected values follow BTN_RELEASE_EVT_EN when the bench is built with it.
module tb_button_event_reader;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEB        = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn_raw = 8'hFF;
  logic [7:0] btn_state;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_chan;
  logic       evt_kind;
  logic       overflow;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  button_event_reader #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W),
    .ACTIVE_LOW(1),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_chan(evt_chan),
    .evt_kind(evt_kind),
    .overflow(overflow)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_raw = 8'hFF;
    evt_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_raw = 8'hFF;
    evt_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) rst_n = 1'b1;
      tick(1);
      tests_run++;
      if (btn_state !== 8'h00 || evt_valid !== 1'b0 || overflow !== 1'b0 ||
          evt_chan !== 3'd0 || evt_kind !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: state=%h valid=%b ovf=%b chan=%0d kind=%b, want 00 0 0 0 0",
                 c, btn_state, evt_valid, overflow, evt_chan, evt_kind);
      end
    end
  endtask

  task automatic test_press_latency();
    logic [7:0] exp_state;
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 8'hF7;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      exp_state = (c == 6) ? 8'h08 : 8'h00;
      tests_run++;
      if (btn_state !== exp_state || evt_valid !== 1'b0) begin
        fails++;
        $display("FAIL press_latency cyc%0d: state=%h valid=%b, want %h 0",
                 c, btn_state, evt_valid, exp_state);
      end
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd3 || evt_kind !== 1'b1) begin
      fails++;
      $display("FAIL press_event: valid=%b chan=%0d kind=%b, want 1 3 1", evt_valid, evt_chan, evt_kind);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b0 || btn_state !== 8'h08) begin
      fails++;
      $display("FAIL press_popped: valid=%b state=%h, want 0 08", evt_valid, btn_state);
    end
  endtask

  task automatic test_release();
    logic [7:0] exp_state;
    logic [2:0] exp_chan;
    btn_raw = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      exp_state = (c == 6) ? 8'h00 : 8'h08;
      tests_run++;
      if (btn_state !== exp_state || evt_valid !== 1'b0) begin
        fails++;
        $display("FAIL release_latency cyc%0d: state=%h valid=%b, want %h 0",
                 c, btn_state, evt_valid, exp_state);
      end
    end
    tick(1);
    exp_chan = REL_EN ? 3'd3 : 3'd0;
    tests_run++;
    if (evt_valid !== REL_EN || evt_chan !== exp_chan || evt_kind !== 1'b0) begin
      fails++;
      $display("FAIL release_event: valid=%b chan=%0d kind=%b, want %b %0d 0",
               evt_valid, evt_chan, evt_kind, REL_EN, exp_chan);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_popped: valid=%b, want 0", evt_valid);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_state;
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 8'hDF;
    tick(3);
    btn_raw = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      tests_run++;
      if (btn_state !== 8'h00 || evt_valid !== 1'b0) begin
        fails++;
        $display("FAIL glitch_reject cyc%0d: state=%h valid=%b, want 00 0", c, btn_state, evt_valid);
      end
    end
    // 3 low, 1 high, then held low: the high cycle restarts the count.
    btn_raw = 8'hDF;
    tick(3);
    btn_raw = 8'hFF;
    tick(1);
    btn_raw = 8'hDF;
    for (int c = 5; c <= 10; c++) begin
      tick(1);
      exp_state = (c == 10) ? 8'h20 : 8'h00;
      tests_run++;
      if (btn_state !== exp_state) begin
        fails++;
        $display("FAIL glitch_restart cyc%0d: state=%h, want %h", c, btn_state, exp_state);
      end
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd5 || evt_kind !== 1'b1) begin
      fails++;
      $display("FAIL glitch_event: valid=%b chan=%0d kind=%b, want 1 5 1", evt_valid, evt_chan, evt_kind);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 8'h7E;
    tick(6);
    tests_run++;
    if (btn_state !== 8'h81) begin
      fails++;
      $display("FAIL b2b_state: state=%h, want 81", btn_state);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd0 || evt_kind !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: valid=%b chan=%0d kind=%b, want 1 0 1", evt_valid, evt_chan, evt_kind);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd7 || evt_kind !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: valid=%b chan=%0d kind=%b, want 1 7 1", evt_valid, evt_chan, evt_kind);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: valid=%b, want 0", evt_valid);
    end
  endtask

  // Presses ch1,4,5,6,2 two cycles apart with no consumer; ends 20 cycles in.
  task automatic fill_five();
    do_reset();
    evt_ready = 1'b0;
    btn_raw = 8'hFD;
    tick(2);
    btn_raw = 8'hED;
    tick(2);
    btn_raw = 8'hCD;
    tick(2);
    btn_raw = 8'h8D;
    tick(2);
    btn_raw = 8'h89;
    tick(12);
  endtask

  task automatic test_fifo_full();
    logic [2:0] exp_chan [5];
    exp_chan = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd2};
    fill_five();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd1 || evt_kind !== 1'b1 ||
        overflow !== 1'b0 || btn_state !== 8'h76) begin
      fails++;
      $display("FAIL full_hold: valid=%b chan=%0d kind=%b ovf=%b state=%h, want 1 1 1 0 76",
               evt_valid, evt_chan, evt_kind, overflow, btn_state);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (evt_valid !== 1'b1 || evt_chan !== exp_chan[k] || evt_kind !== 1'b1 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL full_drain[%0d]: valid=%b chan=%0d kind=%b ovf=%b, want 1 %0d 1 0",
                 k, evt_valid, evt_chan, evt_kind, overflow, exp_chan[k]);
      end
      tick(1);
    end
    tests_run++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: valid=%b, want 0", evt_valid);
    end
  endtask

  task automatic test_pending_collision();
    logic [2:0] exp_chan [5];
    logic       exp_kind [5];
    logic       exp_ovf;
    int         n_exp;
    exp_chan = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd2};
    exp_kind = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n_exp = REL_EN ? 5 : 4;
    fill_five();
    btn_raw = 8'h8D;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      exp_ovf = (c == 6);
      tests_run++;
      if (overflow !== exp_ovf || evt_chan !== 3'd1) begin
        fails++;
        $display("FAIL collide_ovf cyc%0d: ovf=%b chan=%0d, want %b 1", c, overflow, evt_chan, exp_ovf);
      end
    end
    tests_run++;
    if (btn_state !== 8'h72) begin
      fails++;
      $display("FAIL collide_state: state=%h, want 72", btn_state);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < n_exp; k++) begin
      tests_run++;
      if (evt_valid !== 1'b1 || evt_chan !== exp_chan[k] || evt_kind !== exp_kind[k]) begin
        fails++;
        $display("FAIL collide_drain[%0d]: valid=%b chan=%0d kind=%b, want 1 %0d %b",
                 k, evt_valid, evt_chan, evt_kind, exp_chan[k], exp_kind[k]);
      end
      tick(1);
    end
    tick(2);
    tests_run++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL collide_end: valid=%b ovf=%b, want 0 1", evt_valid, overflow);
    end
  endtask

  task automatic test_reset_discard();
    logic [7:0] exp_state;
    do_reset();
    evt_ready = 1'b0;
    btn_raw = 8'hF7;
    tick(4);
    btn_raw = 8'hE7;
    tick(4);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd3) begin
      fails++;
      $display("FAIL discard_pre: valid=%b chan=%0d, want 1 3", evt_valid, evt_chan);
    end
    rst_n = 1'b0;
    btn_raw = 8'hF7;
    tick(2);
    tests_run++;
    if (evt_valid !== 1'b0 || btn_state !== 8'h00 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL discard_in_reset: valid=%b state=%h ovf=%b, want 0 00 0", evt_valid, btn_state, overflow);
    end
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      exp_state = (c == 6) ? 8'h08 : 8'h00;
      tests_run++;
      if (btn_state !== exp_state || evt_valid !== 1'b0) begin
        fails++;
        $display("FAIL held_through_reset cyc%0d: state=%h valid=%b, want %h 0",
                 c, btn_state, evt_valid, exp_state);
      end
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 3'd3 || evt_kind !== 1'b1) begin
      fails++;
      $display("FAIL held_event: valid=%b chan=%0d kind=%b, want 1 3 1", evt_valid, evt_chan, evt_kind);
    end
    tick(1);
    tests_run++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL discard_no_extra: valid=%b, want 0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_release();
    test_glitch();
    test_back_to_back();
    test_fifo_full();
    test_pending_collision();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
